// File: rtl/seg7_pkg.sv
// Shared types and glyph constants for the seven-segment scanner.
// Glyphs are active-high and packed as {g,f,e,d,c,b,a}.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0    = 7'b0111111;
  localparam seg_t SEG_1    = 7'b0000110;
  localparam seg_t SEG_2    = 7'b1011011;
  localparam seg_t SEG_3    = 7'b1001111;
  localparam seg_t SEG_4    = 7'b1100110;
  localparam seg_t SEG_5    = 7'b1101101;
  localparam seg_t SEG_6    = 7'b1111101;
  localparam seg_t SEG_7    = 7'b0000111;
  localparam seg_t SEG_8    = 7'b1111111;
  localparam seg_t SEG_9    = 7'b1101111;
  localparam seg_t SEG_DASH = 7'b1000000;
  localparam seg_t SEG_OFF  = 7'b0000000;

  typedef enum logic [1:0] {
    D0 = 2'd0,
    D1 = 2'd1,
    D2 = 2'd2,
    D3 = 2'd3
  } scan_state_t;

  // One-hot anode pattern for a scan slot, active-high.
  function automatic logic [3:0] slot_onehot(input scan_state_t s);
    logic [3:0] r;
    case (s)
      D0:      r = 4'b0001;
      D1:      r = 4'b0010;
      D2:      r = 4'b0100;
      D3:      r = 4'b1000;
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_to_seg.sv
// Combinational BCD digit to active-high seven-segment glyph.
// Non-decimal codes decode to a single dash.
module bcd_digit_to_seg
  import seg7_pkg::*;
(
  input  logic [3:0] i_digit,
  output seg_t       o_seg
);

  // Glyph lookup.
  always_comb begin
    o_seg = SEG_DASH;
    case (i_digit)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_bcd_scanner.sv
// Four-digit multiplexed seven-segment driver with per-frame snapshot,
// leading-zero blanking, per-digit decimal point and full blank.
module seg7_bcd_scanner
  import seg7_pkg::*;
#(
  parameter int CLK_DIV    = 100000,
  parameter bit BLANK_LZ   = 1'b1,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_bcd,
  input  logic [3:0]  i_dp,
  input  logic        i_blank,
  output logic [3:0]  o_an,
  output logic [6:0]  o_seg,
  output logic        o_dp_n,
  output logic        o_frame_tick
);

  localparam int             CW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_tick;
  scan_state_t   r_state;
  scan_state_t   w_state_next;
  logic          r_frame_tick;
  logic          r_primed;
  logic [15:0]   r_snap_bcd;
  logic [3:0]    r_snap_dp;
  logic [15:0]   w_src_bcd;
  logic [3:0]    w_src_dp;
  logic [3:0]    w_digit;
  logic          w_lz;
  logic          w_dp_bit;
  seg_t          w_glyph;
  logic [3:0]    w_an_act;
  seg_t          w_seg_act;
  logic          w_dp_act;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp_n;

  assign w_tick = (r_cnt == CNT_MAX);

  // Slot divider.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= CW'(0);
    end else if (w_tick) begin
      r_cnt <= CW'(0);
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Scan state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= D0;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Scan next-state: advance one digit per divider tick.
  always_comb begin
    w_state_next = r_state;
    if (w_tick) begin
      case (r_state)
        D0:      w_state_next = D1;
        D1:      w_state_next = D2;
        D2:      w_state_next = D3;
        D3:      w_state_next = D0;
        default: w_state_next = D0;
      endcase
    end else begin
      w_state_next = r_state;
    end
  end

  // Frame pulse coincides with the state register taking D0 after D3.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_tick && (r_state == D3);
    end
  end

  // Snapshot: primed on the first clock out of reset, then once per frame.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_primed   <= 1'b0;
      r_snap_bcd <= 16'h0000;
      r_snap_dp  <= 4'b0000;
    end else if (!r_primed || (w_tick && (r_state == D3))) begin
      r_primed   <= 1'b1;
      r_snap_bcd <= i_bcd;
      r_snap_dp  <= i_dp;
    end else begin
      r_primed   <= r_primed;
      r_snap_bcd <= r_snap_bcd;
      r_snap_dp  <= r_snap_dp;
    end
  end

  // Before priming the snapshot is stale, so show the value being captured.
  always_comb begin
    w_src_bcd = r_snap_bcd;
    w_src_dp  = r_snap_dp;
    if (r_primed) begin
      w_src_bcd = r_snap_bcd;
      w_src_dp  = r_snap_dp;
    end else begin
      w_src_bcd = i_bcd;
      w_src_dp  = i_dp;
    end
  end

  // Digit select and leading-zero test for the current slot.
  always_comb begin
    w_digit  = w_src_bcd[3:0];
    w_lz     = 1'b0;
    w_dp_bit = w_src_dp[0];
    case (r_state)
      D0: begin
        w_digit  = w_src_bcd[3:0];
        w_lz     = 1'b0;
        w_dp_bit = w_src_dp[0];
      end
      D1: begin
        w_digit  = w_src_bcd[7:4];
        w_lz     = BLANK_LZ && (w_src_bcd[15:4] == 12'h000);
        w_dp_bit = w_src_dp[1];
      end
      D2: begin
        w_digit  = w_src_bcd[11:8];
        w_lz     = BLANK_LZ && (w_src_bcd[15:8] == 8'h00);
        w_dp_bit = w_src_dp[2];
      end
      D3: begin
        w_digit  = w_src_bcd[15:12];
        w_lz     = BLANK_LZ && (w_src_bcd[15:12] == 4'h0);
        w_dp_bit = w_src_dp[3];
      end
      default: begin
        w_digit  = 4'h0;
        w_lz     = 1'b0;
        w_dp_bit = 1'b0;
      end
    endcase
  end

  bcd_digit_to_seg u_dec (
    .i_digit (w_digit),
    .o_seg   (w_glyph)
  );

  // Active-high display values; a blanked digit keeps its anode only to light dp.
  always_comb begin
    w_an_act  = 4'b0000;
    w_seg_act = SEG_OFF;
    w_dp_act  = 1'b0;
    if (i_blank) begin
      w_an_act  = 4'b0000;
      w_seg_act = SEG_OFF;
      w_dp_act  = 1'b0;
    end else if (!w_lz) begin
      w_an_act  = slot_onehot(r_state);
      w_seg_act = w_glyph;
      w_dp_act  = w_dp_bit;
    end else if (w_dp_bit) begin
      w_an_act  = slot_onehot(r_state);
      w_seg_act = SEG_OFF;
      w_dp_act  = 1'b1;
    end else begin
      w_an_act  = 4'b0000;
      w_seg_act = SEG_OFF;
      w_dp_act  = 1'b0;
    end
  end

  // Output register; polarity is applied only here.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_an   <= {4{ACTIVE_LOW}};
      r_seg  <= {7{ACTIVE_LOW}};
      r_dp_n <= ACTIVE_LOW;
    end else begin
      r_an   <= w_an_act ^ {4{ACTIVE_LOW}};
      r_seg  <= w_seg_act ^ {7{ACTIVE_LOW}};
      r_dp_n <= w_dp_act ^ ACTIVE_LOW;
    end
  end

  assign o_an         = r_an;
  assign o_seg        = r_seg;
  assign o_dp_n       = r_dp_n;
  assign o_frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg7_bcd_scanner.sv
// Randomised self-checking bench for seg7_bcd_scanner (CLK_DIV=4, active-low, LZ blanking).
// The reference model works from elapsed clocks since reset release.
module tb_seg7_bcd_scanner;

  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] bcd = 16'h0000;
  logic [3:0]  dp = 4'b0000;
  logic        blank = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;

  int          m = 0;
  logic [15:0] m_bcd = 16'h0000;
  logic [3:0]  m_dp = 4'b0000;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp_n;
  logic        e_ft;

  seg7_bcd_scanner #(.CLK_DIV(DIV), .BLANK_LZ(1'b1), .ACTIVE_LOW(1'b1)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_bcd        (bcd),
    .i_dp         (dp),
    .i_blank      (blank),
    .o_an         (an),
    .o_seg        (seg),
    .o_dp_n       (dp_n),
    .o_frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input int v);
    case (v)
      0: return 7'b0111111;
      1: return 7'b0000110;
      2: return 7'b1011011;
      3: return 7'b1001111;
      4: return 7'b1100110;
      5: return 7'b1101101;
      6: return 7'b1111101;
      7: return 7'b0000111;
      8: return 7'b1111111;
      9: return 7'b1101111;
      default: return 7'b1000000;
    endcase
  endfunction

  // Advance one clock, predict the outputs after it, and settle for sampling.
  task automatic step();
    int slot;
    int d;
    bit lz;
    bit dpb;
    logic [3:0] an_a;
    logic [6:0] seg_a;
    bit dp_a;
    @(posedge clk);
    if (rst) begin
      m = 0;
      m_bcd = 16'h0000;
      m_dp = 4'b0000;
      e_an = 4'b1111;
      e_seg = 7'b1111111;
      e_dp_n = 1'b1;
      e_ft = 1'b0;
    end else begin
      m = m + 1;
      if (m == 1) begin
        m_bcd = bcd;
        m_dp = dp;
      end
      slot = ((m - 1) / DIV) % 4;
      d = int'((m_bcd >> (4 * slot)) & 16'h000F);
      lz = (slot > 0) && ((m_bcd >> (4 * slot)) == 16'h0000);
      dpb = m_dp[slot];
      an_a = 4'b0000;
      seg_a = 7'b0000000;
      dp_a = 1'b0;
      if (!blank) begin
        dp_a = dpb;
        if (!lz) begin
          an_a = 4'(1 << slot);
          seg_a = glyph(d);
        end else if (dpb) begin
          an_a = 4'(1 << slot);
        end
      end
      e_an = ~an_a;
      e_seg = ~seg_a;
      e_dp_n = ~dp_a;
      e_ft = (m % FRAME == 0);
      if (m % FRAME == 0) begin
        m_bcd = bcd;
        m_dp = dp;
      end
    end
    #1;
  endtask

  function automatic int model_state();
    return (m / DIV) % 4;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bcd = 16'h1234;
    dp = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (an !== 4'b1111 || seg !== 7'b1111111 || dp_n !== 1'b1 || frame_tick !== 1'b0) begin
        errors++;
        $display("FAIL reset_dark an=%b seg=%b dp_n=%b ft=%b expected 1111/1111111/1/0", an, seg, dp_n, frame_tick);
      end
    end
    rst = 1'b0;
    step();
    checks++;
    if (an !== 4'b1110 || seg !== 7'b0011001) begin
      errors++;
      $display("FAIL first_digit an=%b seg=%b expected 1110/0011001", an, seg);
    end
    for (int i = 0; i < 40; i++) begin
      step();
      checks++;
      if (an !== e_an || seg !== e_seg || dp_n !== e_dp_n || frame_tick !== e_ft) begin
        errors++;
        $display("FAIL scan_1234 m=%0d an=%b/%b seg=%b/%b dp_n=%b/%b ft=%b/%b",
                 m, an, e_an, seg, e_seg, dp_n, e_dp_n, frame_tick, e_ft);
      end
    end
  endtask

  task automatic test_lz();
    bcd = 16'h0007;
    for (int i = 0; i < 3 * FRAME; i++) begin
      step();
      checks++;
      if (an !== e_an || seg !== e_seg || dp_n !== e_dp_n || frame_tick !== e_ft) begin
        errors++;
        $display("FAIL lz_0007 m=%0d an=%b/%b seg=%b/%b", m, an, e_an, seg, e_seg);
      end
      if (m > FRAME + 1 && ((m - 1) / DIV) % 4 == 0) begin
        checks++;
        if (an !== 4'b1110 || seg !== 7'b1111000) begin
          errors++;
          $display("FAIL lz_d0_7 an=%b seg=%b expected 1110/1111000", an, seg);
        end
      end
    end
    bcd = 16'h0000;
    for (int i = 0; i < 3 * FRAME; i++) begin
      step();
      checks++;
      if (an !== e_an || seg !== e_seg || dp_n !== e_dp_n || frame_tick !== e_ft) begin
        errors++;
        $display("FAIL lz_0000 m=%0d an=%b/%b seg=%b/%b", m, an, e_an, seg, e_seg);
      end
    end
  endtask

  task automatic test_midframe();
    bcd = 16'h1234;
    for (int i = 0; i < 2 * FRAME; i++) step();
    for (int i = 0; i < FRAME && model_state() != 1; i++) step();
    bcd = 16'h5678;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      checks++;
      if (an !== e_an || seg !== e_seg || dp_n !== e_dp_n || frame_tick !== e_ft) begin
        errors++;
        $display("FAIL midframe m=%0d an=%b/%b seg=%b/%b", m, an, e_an, seg, e_seg);
      end
    end
  endtask

  task automatic test_dash_dp();
    bcd = 16'h00A5;
    dp = 4'b0100;
    for (int i = 0; i < 3 * FRAME; i++) begin
      step();
      checks++;
      if (an !== e_an || seg !== e_seg || dp_n !== e_dp_n || frame_tick !== e_ft) begin
        errors++;
        $display("FAIL dash_dp m=%0d an=%b/%b seg=%b/%b dp_n=%b/%b", m, an, e_an, seg, e_seg, dp_n, e_dp_n);
      end
    end
    dp = 4'b0000;
  endtask

  task automatic test_blank();
    int last_ft;
    bcd = 16'h4321;
    for (int i = 0; i < 2 * FRAME; i++) step();
    last_ft = -1;
    for (int i = 0; i < 4 * FRAME; i++) begin
      if (i == 6) blank = 1'b1;
      if (i == 16) blank = 1'b0;
      step();
      checks++;
      if (an !== e_an || seg !== e_seg || dp_n !== e_dp_n || frame_tick !== e_ft) begin
        errors++;
        $display("FAIL blank m=%0d blank=%b an=%b/%b seg=%b/%b", m, blank, an, e_an, seg, e_seg);
      end
      if (frame_tick === 1'b1) begin
        if (last_ft >= 0) begin
          checks++;
          if (i - last_ft != FRAME) begin
            errors++;
            $display("FAIL ft_spacing got %0d expected %0d", i - last_ft, FRAME);
          end
        end
        last_ft = i;
      end
    end
  endtask

  task automatic test_rst_pulse();
    bcd = 16'h1234;
    for (int i = 0; i < 2 * FRAME; i++) step();
    for (int i = 0; i < FRAME && model_state() != 2; i++) step();
    step();
    bcd = 16'h9876;
    rst = 1'b1;
    step();
    checks++;
    if (an !== 4'b1111 || seg !== 7'b1111111 || dp_n !== 1'b1 || frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL rst_pulse_dark an=%b seg=%b dp_n=%b ft=%b", an, seg, dp_n, frame_tick);
    end
    rst = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      checks++;
      if (an !== e_an || seg !== e_seg || dp_n !== e_dp_n || frame_tick !== e_ft) begin
        errors++;
        $display("FAIL rst_reprime m=%0d an=%b/%b seg=%b/%b", m, an, e_an, seg, e_seg);
      end
    end
  endtask

  task automatic test_random();
    int nz;
    logic [15:0] v;
    for (int i = 0; i < 800; i++) begin
      step();
      checks++;
      if (an !== e_an || seg !== e_seg || dp_n !== e_dp_n || frame_tick !== e_ft) begin
        errors++;
        $display("FAIL random m=%0d bcd=%h an=%b/%b seg=%b/%b dp_n=%b/%b ft=%b/%b",
                 m, m_bcd, an, e_an, seg, e_seg, dp_n, e_dp_n, frame_tick, e_ft);
      end
      if ($urandom_range(0, 6) == 0) begin
        v = 16'($urandom);
        nz = $urandom_range(0, 4);
        if (nz > 0) v = v & (16'hFFFF >> (4 * nz));
        bcd = v;
        dp = 4'($urandom);
      end
      blank = ($urandom_range(0, 15) == 0);
    end
    blank = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lz();
    test_midframe();
    test_dash_dp();
    test_blank();
    test_rst_pulse();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
